// File: rtl/sudoku_pkg.sv
// Shared types and board-geometry helpers for the parametrised Sudoku core.
// Geometry is derived from the box edge so every file agrees on N, CELLS and widths.
package sudoku_pkg;

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_CHECK = 1'b1
  } state_t;

  function automatic int calc_n(input int box);
    return box * box;
  endfunction

  function automatic int calc_cells(input int box);
    return calc_n(box) * calc_n(box);
  endfunction

  function automatic int calc_dw(input int box);
    return $clog2(calc_n(box) + 1);
  endfunction

  function automatic int calc_iw(input int box);
    return $clog2(calc_cells(box));
  endfunction

  // Cell index of member j of unit u: units 0..N-1 are rows, N..2N-1 columns, 2N..3N-1 boxes.
  function automatic int unit_cell(input int box, input int u, input int j);
    int n;
    int b;
    int r;
    int c;
    n = box * box;
    b = 0;
    r = 0;
    c = 0;
    if (u < n) begin
      r = u;
      c = j;
    end else if (u < 2 * n) begin
      r = j;
      c = u - n;
    end else begin
      b = u - 2 * n;
      r = (b / box) * box + j / box;
      c = (b % box) * box + j % box;
    end
    return r * n + c;
  endfunction

endpackage

// File: rtl/sudoku_unit_check.sv
// Combinational rule check of one Sudoku unit (row, column or box) of N digits.
// Reports a repeated nonzero digit and the presence of any empty cell.
module sudoku_unit_check #(
  parameter int N  = 9,
  parameter int DW = 4
) (
  input  logic [N*DW-1:0] digits,
  output logic            dup,
  output logic            has_empty
);

  logic [(1<<DW)-1:0] seen_s;
  logic [DW-1:0]      d_s;

  // Seen-bitmask scan; bit 0 doubles as the empty marker and never counts as a duplicate
  always_comb begin
    seen_s    = '0;
    d_s       = '0;
    dup       = 1'b0;
    has_empty = 1'b0;
    for (int j = 0; j < N; j++) begin
      d_s       = digits[j*DW +: DW];
      has_empty = has_empty | (d_s == '0);
      dup       = dup | ((d_s != '0) & seen_s[d_s]);
      seen_s[d_s] = 1'b1;
    end
  end

endmodule

// File: rtl/sudoku_board_core.sv
// Sudoku board core: cursor, guarded digit writes, bounded undo ring and a
// one-unit-per-cycle rule checker that drives win/conflict.
module sudoku_board_core
  import sudoku_pkg::*;
#(
  parameter  int BOX        = 3,
  parameter  int UNDO_DEPTH = 16,
  localparam int N          = calc_n(BOX),
  localparam int CELLS      = calc_cells(BOX),
  localparam int DW         = calc_dw(BOX),
  localparam int IW         = calc_iw(BOX)
) (
  input  logic                CLK_100MHz,
  input  logic                RST,
  input  logic                UP,
  input  logic                DOWN,
  input  logic                LEFT,
  input  logic                RIGHT,
  input  logic                load,
  input  logic [CELLS*DW-1:0] load_map,
  input  logic [CELLS-1:0]    load_mask,
  input  logic                num_valid,
  input  logic [DW-1:0]       num_code,
  input  logic                undo,
  output logic [CELLS*DW-1:0] cur_map,
  output logic [IW-1:0]       cur_select,
  output logic [CELLS-1:0]    read_only,
  output logic                busy,
  output logic                undo_empty,
  output logic                win,
  output logic                conflict
);

  localparam int RW = (N > 1) ? $clog2(N) : 1;
  localparam int UN = 3 * N;
  localparam int UW = $clog2(UN);
  localparam int HW = $clog2(UNDO_DEPTH);
  localparam int CW = HW + 1;

  logic [RW-1:0]       row_q, row_d, col_q, col_d;
  logic [IW-1:0]       sel_q, sel_d;
  logic [CELLS*DW-1:0] map_q, map_d;
  logic [CELLS-1:0]    ro_q, ro_d;
  state_t              state_q, state_d;
  logic [UW-1:0]       unit_q, unit_d;
  logic                dup_acc_q, dup_acc_d, empty_acc_q, empty_acc_d;
  logic                win_q, win_d, conflict_q, conflict_d;
  logic                busy_q, busy_d, undo_empty_q, undo_empty_d;
  logic [HW-1:0]       hptr_q, hptr_d;
  logic [CW-1:0]       hcnt_q, hcnt_d;
  logic [IW-1:0]       hist_idx_q [UNDO_DEPTH];
  logic [DW-1:0]       hist_val_q [UNDO_DEPTH];

  logic                idle_s, do_load_s, do_undo_s, do_write_s, push_s;
  logic [DW-1:0]       cell_val_s;
  logic [HW-1:0]       top_ptr_s;
  logic [N*DW-1:0]     unit_digits_s;
  logic                unit_dup_s, unit_empty_s;

  // Command arbitration: load beats undo beats write, and nothing is taken while checking
  always_comb begin
    idle_s     = (state_q == S_IDLE);
    cell_val_s = map_q[int'(sel_q)*DW +: DW];
    top_ptr_s  = hptr_q - HW'(1);
    do_load_s  = idle_s & load;
    do_undo_s  = idle_s & ~load & undo & (hcnt_q != '0);
    do_write_s = idle_s & ~load & ~undo & num_valid & ~ro_q[sel_q]
               & (num_code <= DW'(N)) & (num_code != cell_val_s) & ~win_q;
  end

  // Cursor with wrap-around; opposing pulses cancel per axis
  always_comb begin
    row_d = row_q;
    col_d = col_q;
    if (do_load_s) begin
      row_d = '0;
      col_d = '0;
    end else begin
      if (UP & ~DOWN) begin
        row_d = (row_q == '0) ? RW'(N - 1) : row_q - RW'(1);
      end else if (DOWN & ~UP) begin
        row_d = (row_q == RW'(N - 1)) ? '0 : row_q + RW'(1);
      end else begin
        row_d = row_q;
      end
      if (LEFT & ~RIGHT) begin
        col_d = (col_q == '0) ? RW'(N - 1) : col_q - RW'(1);
      end else if (RIGHT & ~LEFT) begin
        col_d = (col_q == RW'(N - 1)) ? '0 : col_q + RW'(1);
      end else begin
        col_d = col_q;
      end
    end
    sel_d = IW'(int'(row_d) * N + int'(col_d));
  end

  // Board contents and undo ring bookkeeping; a full ring silently overwrites its oldest entry
  always_comb begin
    map_d  = map_q;
    ro_d   = ro_q;
    hptr_d = hptr_q;
    hcnt_d = hcnt_q;
    push_s = 1'b0;
    if (do_load_s) begin
      map_d  = load_map;
      ro_d   = load_mask;
      hptr_d = '0;
      hcnt_d = '0;
    end else if (do_undo_s) begin
      map_d[int'(hist_idx_q[top_ptr_s])*DW +: DW] = hist_val_q[top_ptr_s];
      hptr_d = top_ptr_s;
      hcnt_d = hcnt_q - CW'(1);
    end else if (do_write_s) begin
      push_s = 1'b1;
      map_d[int'(sel_q)*DW +: DW] = num_code;
      hptr_d = hptr_q + HW'(1);
      hcnt_d = (hcnt_q == CW'(UNDO_DEPTH)) ? hcnt_q : hcnt_q + CW'(1);
    end else begin
      push_s = 1'b0;
    end
    undo_empty_d = (hcnt_d == '0);
  end

  // Gather the digits of the unit under inspection
  always_comb begin
    unit_digits_s = '0;
    for (int j = 0; j < N; j++) begin
      unit_digits_s[j*DW +: DW] = map_q[unit_cell(BOX, int'(unit_q), j)*DW +: DW];
    end
  end

  sudoku_unit_check #(
    .N  (N),
    .DW (DW)
  ) u_unit_check (
    .digits    (unit_digits_s),
    .dup       (unit_dup_s),
    .has_empty (unit_empty_s)
  );

  // Checker FSM: flags are published only when the last unit has been folded in
  always_comb begin
    state_d     = state_q;
    unit_d      = unit_q;
    dup_acc_d   = dup_acc_q;
    empty_acc_d = empty_acc_q;
    win_d       = win_q;
    conflict_d  = conflict_q;
    case (state_q)
      S_IDLE: begin
        if (do_load_s | do_undo_s | do_write_s) begin
          state_d     = S_CHECK;
          unit_d      = '0;
          dup_acc_d   = 1'b0;
          empty_acc_d = 1'b0;
        end else begin
          state_d = S_IDLE;
        end
        if (do_load_s) begin
          win_d = 1'b0;
        end else begin
          win_d = win_q;
        end
      end
      S_CHECK: begin
        dup_acc_d   = dup_acc_q | unit_dup_s;
        empty_acc_d = empty_acc_q | unit_empty_s;
        if (unit_q == UW'(UN - 1)) begin
          state_d    = S_IDLE;
          conflict_d = dup_acc_d;
          win_d      = ~dup_acc_d & ~empty_acc_d;
        end else begin
          unit_d = unit_q + UW'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    busy_d = (state_d == S_CHECK);
  end

  // Architectural registers
  always_ff @(posedge CLK_100MHz or posedge RST) begin
    if (RST) begin
      row_q        <= '0;
      col_q        <= '0;
      sel_q        <= '0;
      map_q        <= '0;
      ro_q         <= '0;
      state_q      <= S_IDLE;
      unit_q       <= '0;
      dup_acc_q    <= 1'b0;
      empty_acc_q  <= 1'b0;
      win_q        <= 1'b0;
      conflict_q   <= 1'b0;
      busy_q       <= 1'b0;
      undo_empty_q <= 1'b1;
      hptr_q       <= '0;
      hcnt_q       <= '0;
    end else begin
      row_q        <= row_d;
      col_q        <= col_d;
      sel_q        <= sel_d;
      map_q        <= map_d;
      ro_q         <= ro_d;
      state_q      <= state_d;
      unit_q       <= unit_d;
      dup_acc_q    <= dup_acc_d;
      empty_acc_q  <= empty_acc_d;
      win_q        <= win_d;
      conflict_q   <= conflict_d;
      busy_q       <= busy_d;
      undo_empty_q <= undo_empty_d;
      hptr_q       <= hptr_d;
      hcnt_q       <= hcnt_d;
    end
  end

  // Undo storage needs no reset: the entry count alone says what is valid
  always_ff @(posedge CLK_100MHz) begin
    if (push_s) begin
      hist_idx_q[hptr_q] <= sel_q;
      hist_val_q[hptr_q] <= cell_val_s;
    end
  end

  assign cur_map    = map_q;
  assign cur_select = sel_q;
  assign read_only  = ro_q;
  assign busy       = busy_q;
  assign undo_empty = undo_empty_q;
  assign win        = win_q;
  assign conflict   = conflict_q;

endmodule

// File: tb/tb_sudoku_board_core.sv
// Self-checking bench: a 9x9 core driven by directed and random commands against a
// cell-array reference model, plus a 4x4 core for priority, busy-drop and reset cases.
module tb_sudoku_board_core;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // 9x9 instance
  logic         rst = 1'b1;
  logic         up = 1'b0, dn = 1'b0, lf = 1'b0, rt = 1'b0;
  logic         load = 1'b0, num_valid = 1'b0, undo = 1'b0;
  logic [323:0] load_map = '0;
  logic [80:0]  load_mask = '0;
  logic [3:0]   num_code = '0;
  logic [323:0] cur_map;
  logic [6:0]   cur_select;
  logic [80:0]  read_only;
  logic         busy, undo_empty, win, conflict;

  sudoku_board_core #(.BOX(3), .UNDO_DEPTH(16)) dut (
    .CLK_100MHz(clk), .RST(rst), .UP(up), .DOWN(dn), .LEFT(lf), .RIGHT(rt),
    .load(load), .load_map(load_map), .load_mask(load_mask),
    .num_valid(num_valid), .num_code(num_code), .undo(undo),
    .cur_map(cur_map), .cur_select(cur_select), .read_only(read_only),
    .busy(busy), .undo_empty(undo_empty), .win(win), .conflict(conflict)
  );

  // 4x4 instance
  logic        b_rst = 1'b1;
  logic [3:0]  b_mv = '0;
  logic        b_load = 1'b0, b_nv = 1'b0, b_undo = 1'b0;
  logic [47:0] b_map = '0;
  logic [15:0] b_mask = '0;
  logic [2:0]  b_code = '0;
  logic [47:0] b_cur_map;
  logic [3:0]  b_sel;
  logic [15:0] b_ro;
  logic        b_busy, b_ue, b_win, b_conf;

  sudoku_board_core #(.BOX(2), .UNDO_DEPTH(4)) dut2 (
    .CLK_100MHz(clk), .RST(b_rst), .UP(b_mv[3]), .DOWN(b_mv[2]), .LEFT(b_mv[1]), .RIGHT(b_mv[0]),
    .load(b_load), .load_map(b_map), .load_mask(b_mask),
    .num_valid(b_nv), .num_code(b_code), .undo(b_undo),
    .cur_map(b_cur_map), .cur_select(b_sel), .read_only(b_ro),
    .busy(b_busy), .undo_empty(b_ue), .win(b_win), .conflict(b_conf)
  );

  int checks = 0;
  int failures = 0;

  // Reference model of the 9x9 game
  typedef struct { int idx; int val; } hent_t;
  int    bd [81];
  bit    ro_m [81];
  int    sol_m [81];
  int    row_m = 0, col_m = 0;
  hent_t hist [$];
  bit    win_m = 1'b0, conf_m = 1'b0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [323:0] model_map();
    logic [323:0] m;
    m = '0;
    for (int k = 0; k < 81; k++) m[k*4 +: 4] = 4'(bd[k]);
    return m;
  endfunction

  function automatic logic [80:0] model_mask();
    logic [80:0] m;
    m = '0;
    for (int k = 0; k < 81; k++) m[k] = ro_m[k];
    return m;
  endfunction

  // Rules stated directly: any two cells sharing a row, column or box with the same nonzero digit
  function automatic void model_eval(output bit dup, output bit full);
    dup = 1'b0;
    full = 1'b1;
    for (int a = 0; a < 81; a++) begin
      if (bd[a] == 0) full = 1'b0;
      for (int b = a + 1; b < 81; b++) begin
        if (bd[a] != 0 && bd[a] == bd[b] &&
            (a / 9 == b / 9 || a % 9 == b % 9 ||
             ((a / 9) / 3 == (b / 9) / 3 && (a % 9) / 3 == (b % 9) / 3)))
          dup = 1'b1;
      end
    end
  endfunction

  function automatic void move_model(input bit [3:0] mv);
    if (mv[3] && !mv[2]) row_m = (row_m + 8) % 9;
    else if (mv[2] && !mv[3]) row_m = (row_m + 1) % 9;
    if (mv[1] && !mv[0]) col_m = (col_m + 8) % 9;
    else if (mv[0] && !mv[1]) col_m = (col_m + 1) % 9;
  endfunction

  function automatic logic [323:0] sol_grid(input int k);
    logic [323:0] m;
    m = '0;
    for (int r = 0; r < 9; r++)
      for (int c = 0; c < 9; c++)
        m[(r*9+c)*4 +: 4] = 4'(((r * 3 + r / 3 + c + k) % 9) + 1);
    return m;
  endfunction

  // One stimulus cycle on the 9x9 core, model update, and wait-out of any resulting check
  task automatic apply(input bit ld, input bit un, input bit nv, input int code, input bit [3:0] mv,
                       input bit mv_busy, input logic [323:0] lm, input logic [80:0] lk);
    bit    started;
    bit    dup, full;
    int    n;
    int    sel;
    hent_t h;
    load = ld; undo = un; num_valid = nv; num_code = 4'(code);
    {up, dn, lf, rt} = mv; load_map = lm; load_mask = lk;
    tick();
    load = 1'b0; undo = 1'b0; num_valid = 1'b0; {up, dn, lf, rt} = 4'b0000;
    sel = row_m * 9 + col_m;
    started = 1'b0;
    if (ld) begin
      for (int k = 0; k < 81; k++) begin
        bd[k] = int'(lm[k*4 +: 4]);
        ro_m[k] = lk[k];
      end
      hist.delete();
      win_m = 1'b0;
      started = 1'b1;
    end else if (un) begin
      if (hist.size() > 0) begin
        h = hist.pop_back();
        bd[h.idx] = h.val;
        started = 1'b1;
      end
    end else if (nv) begin
      if (!ro_m[sel] && code <= 9 && bd[sel] != code && !win_m) begin
        h.idx = sel;
        h.val = bd[sel];
        hist.push_back(h);
        if (hist.size() > 16) void'(hist.pop_front());
        bd[sel] = code;
        started = 1'b1;
      end
    end
    if (ld) begin
      row_m = 0;
      col_m = 0;
    end else begin
      move_model(mv);
    end
    chk("map", cur_map, model_map());
    chk("ro", read_only, model_mask());
    chk("sel", cur_select, row_m * 9 + col_m);
    chk("undo_empty", undo_empty, hist.size() == 0);
    chk("busy_start", busy, started);
    chk("win_hold", win, win_m);
    chk("conf_hold", conflict, conf_m);
    if (started) begin
      n = 0;
      while (busy === 1'b1 && n < 100) begin
        if (mv_busy && n == 5) begin
          lf = 1'b1;
          move_model(4'b0010);
        end
        tick();
        lf = 1'b0;
        n++;
      end
      chk("busy_len", n, 27);
      model_eval(dup, full);
      conf_m = dup;
      win_m = !dup && full;
      chk("win", win, win_m);
      chk("conflict", conflict, conf_m);
      chk("sel_after", cur_select, row_m * 9 + col_m);
      chk("map_after", cur_map, model_map());
    end
  endtask

  initial begin
    logic [323:0] sol, puz, rmap;
    logic [80:0]  mask, rmask;
    logic [47:0]  sol2, puz2;
    int           n;

    for (int k = 0; k < 81; k++) begin
      bd[k] = 0;
      ro_m[k] = 1'b0;
    end
    repeat (2) tick();
    rst = 1'b0;
    b_rst = 1'b0;
    tick();

    chk("rst_map", cur_map, 324'd0);
    chk("rst_ro", read_only, 81'd0);
    chk("rst_sel", cur_select, 7'd0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_win", win, 1'b0);
    chk("rst_conf", conflict, 1'b0);
    chk("rst_ue", undo_empty, 1'b1);

    for (int i = 0; i < 10; i++) apply(1'b0, 1'b0, 1'b0, 0, 4'b0010, 1'b0, '0, '0);
    chk("left10_sel", cur_select, 7'd8);

    sol = sol_grid(1);
    puz = sol;
    puz[3:0] = 4'd0;
    mask = '1;
    mask[0] = 1'b0;
    apply(1'b1, 1'b0, 1'b0, 0, 4'b0000, 1'b0, puz, mask);
    apply(1'b0, 1'b0, 1'b1, 2, 4'b0000, 1'b0, '0, '0);
    chk("solve_win", win, 1'b1);
    chk("solve_conf", conflict, 1'b0);
    apply(1'b0, 1'b0, 1'b1, 5, 4'b0000, 1'b0, '0, '0);

    apply(1'b1, 1'b0, 1'b0, 0, 4'b0000, 1'b0, puz, mask);
    apply(1'b0, 1'b0, 1'b1, 3, 4'b0000, 1'b0, '0, '0);
    chk("dup_conf", conflict, 1'b1);
    chk("dup_win", win, 1'b0);
    apply(1'b0, 1'b1, 1'b0, 0, 4'b0000, 1'b0, '0, '0);
    chk("undo_cell0", cur_map[3:0], 4'd0);
    chk("undo_conf", conflict, 1'b0);
    chk("undo_ue", undo_empty, 1'b1);

    apply(1'b0, 1'b0, 1'b0, 0, 4'b0001, 1'b0, '0, '0);
    apply(1'b0, 1'b0, 1'b1, 5, 4'b0000, 1'b0, '0, '0);
    apply(1'b0, 1'b0, 1'b0, 0, 4'b0010, 1'b0, '0, '0);
    apply(1'b0, 1'b0, 1'b1, 10, 4'b0000, 1'b0, '0, '0);
    apply(1'b0, 1'b1, 1'b0, 0, 4'b0000, 1'b0, '0, '0);

    apply(1'b1, 1'b0, 1'b0, 0, 4'b0000, 1'b0, '0, '0);
    for (int i = 0; i < 17; i++) apply(1'b0, 1'b0, 1'b1, (i % 9) + 1, 4'b0000, 1'b0, '0, '0);
    for (int i = 0; i < 17; i++) apply(1'b0, 1'b1, 1'b0, 0, 4'b0000, 1'b0, '0, '0);
    chk("depth_cell0", cur_map[3:0], 4'd1);
    apply(1'b0, 1'b1, 1'b1, 4, 4'b0000, 1'b0, '0, '0);

    rmap = sol_grid(int'($urandom_range(0, 8)));
    rmask = '1;
    for (int k = 0; k < 81; k++) begin
      sol_m[k] = int'(rmap[k*4 +: 4]);
      if ($urandom_range(0, 99) < 40) begin
        rmap[k*4 +: 4] = 4'd0;
        rmask[k] = 1'b0;
      end
    end
    apply(1'b1, 1'b0, 1'b0, 0, 4'b0000, 1'b0, rmap, rmask);
    for (int it = 0; it < 150; it++) begin
      int op;
      int code;
      bit [3:0] mv;
      op = int'($urandom_range(0, 19));
      mv = 4'($urandom_range(0, 15));
      code = ($urandom_range(0, 1) == 1) ? sol_m[row_m * 9 + col_m] : int'($urandom_range(0, 10));
      if (op == 0) apply(1'b1, 1'b0, 1'b0, 0, 4'b0000, 1'b0, rmap, rmask);
      else if (op < 7) apply(1'b0, 1'b0, 1'b0, 0, mv, 1'b0, '0, '0);
      else if (op < 14) apply(1'b0, 1'b0, 1'b1, code, 4'b0000, op == 13, '0, '0);
      else if (op < 18) apply(1'b0, 1'b1, 1'b0, 0, 4'b0000, 1'b0, '0, '0);
      else apply(1'b0, 1'b1, 1'b1, code, mv, 1'b1, '0, '0);
    end

    // 4x4 core: load beats a same-cycle write, writes during busy vanish, reset aborts a check
    chk("b_rst_map", b_cur_map, 48'd0);
    chk("b_rst_busy", b_busy, 1'b0);
    chk("b_rst_ue", b_ue, 1'b1);
    sol2 = '0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        sol2[(r*4+c)*3 +: 3] = 3'(((r * 2 + r / 2 + c) % 4) + 1);
    puz2 = sol2;
    puz2[2:0] = 3'd0;
    b_load = 1'b1; b_nv = 1'b1; b_code = 3'd1; b_map = puz2; b_mask = 16'hFFFE;
    tick();
    b_load = 1'b0; b_nv = 1'b0;
    chk("b_load_wins", b_cur_map, puz2);
    chk("b_load_ro", b_ro, 16'hFFFE);
    chk("b_load_busy", b_busy, 1'b1);
    n = 0;
    while (b_busy === 1'b1 && n < 50) begin
      if (n == 3) b_nv = 1'b1;
      tick();
      b_nv = 1'b0;
      n++;
    end
    chk("b_busy_len", n, 12);
    chk("b_drop_map", b_cur_map, puz2);
    chk("b_drop_ue", b_ue, 1'b1);
    chk("b_load_win", b_win, 1'b0);
    b_nv = 1'b1; b_code = 3'd1;
    tick();
    b_nv = 1'b0;
    chk("b_write_map", b_cur_map, sol2);
    n = 0;
    while (b_busy === 1'b1 && n < 50) begin
      tick();
      n++;
    end
    chk("b_write_len", n, 12);
    chk("b_win", b_win, 1'b1);
    chk("b_conf", b_conf, 1'b0);
    b_undo = 1'b1;
    tick();
    b_undo = 1'b0;
    chk("b_undo_map", b_cur_map, puz2);
    chk("b_undo_busy", b_busy, 1'b1);
    chk("b_undo_winhold", b_win, 1'b1);
    repeat (4) tick();
    b_rst = 1'b1;
    #2;
    chk("b_midrst_busy", b_busy, 1'b0);
    chk("b_midrst_win", b_win, 1'b0);
    tick();
    b_rst = 1'b0;
    tick();
    chk("b_rst2_map", b_cur_map, 48'd0);
    chk("b_rst2_ro", b_ro, 16'd0);
    chk("b_rst2_sel", b_sel, 4'd0);
    chk("b_rst2_busy", b_busy, 1'b0);
    chk("b_rst2_win", b_win, 1'b0);
    chk("b_rst2_conf", b_conf, 1'b0);
    chk("b_rst2_ue", b_ue, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sudoku_board_core.md
# sudoku_board_core

Parametrised successor to the fixed 9x9 game core: holds an N×N Sudoku board (N = BOX²), a cursor driven by direction pulses, a digit write path that respects read-only givens, a bounded undo history, and a sequential rule checker that produces `win`/`conflict`. It sits between the keypad/button front end (debounced one-cycle pulses) and the VGA/LED renderer, which reads `cur_map`, `cur_select` and `read_only` directly.

## Interface
- `BOX`, default 3: box edge. N = BOX², CELLS = N², DW = $clog2(N+1), IW = $clog2(CELLS).
- `UNDO_DEPTH`, default 16: undo history entries (power of two, ≥2).
- `CLK_100MHz`  in  1  system clock.
- `RST`  in  1  asynchronous, active-high reset; one clock; reset is asynchronous and active-high.
- `UP`, `DOWN`, `LEFT`, `RIGHT`  in  1 each  one-cycle cursor move pulses.
- `load`  in  1  one-cycle pulse: load new puzzle.
- `load_map`  in  CELLS*DW  puzzle digits; cell k at `[k*DW +: DW]`, k = row*N+col, 0 = empty.
- `load_mask`  in  CELLS  1 = given (read-only) cell.
- `num_valid`  in  1  one-cycle pulse: write `num_code` at cursor.
- `num_code`  in  DW  digit 0..N (0 clears).
- `undo`  in  1  one-cycle pulse: revert last write.
- `cur_map`  out  CELLS*DW  current board.
- `cur_select`  out  IW  cursor cell index.
- `read_only`  out  CELLS  given-cell mask.
- `busy`  out  1  checker running.
- `undo_empty`  out  1  history empty.
- `win`  out  1  board full and rule-valid (sticky until `load`/reset).
- `conflict`  out  1  some row/col/box holds a duplicate nonzero digit.

## Operation
- Reset: `cur_map`=0, `read_only`=0, `cur_select`=0, `busy`=0, `win`=0, `conflict`=0, `undo_empty`=1, history cleared, FSM in S_IDLE.
- Cursor: row/col registers, wrap-around (UP from row 0 → row N-1, RIGHT from col N-1 → col 0). Moves accepted in any state, including `busy`. Opposing pulses in the same cycle cancel on that axis; UP+LEFT moves both axes.
- Command priority when several pulse together: `load` > `undo` > `num_valid`; lower ones are dropped. Commands are accepted only when `busy`=0; pulses while busy are dropped, not queued.
- `load`: `cur_map`←`load_map`, `read_only`←`load_mask`, cursor→0, history cleared, `win`←0, then check starts.
- Write: ignored (no push, no check) if cell read-only, `num_code` > N, value equals current cell, or `win`=1. Otherwise push {index, old value}, update cell, start check.
- History: LIFO ring of UNDO_DEPTH; push when full overwrites the oldest entry. `undo` when empty is a no-op; otherwise pop and restore old value at stored index (cursor unchanged, read-only not rechecked since givens never get pushed), start check.
- Checker FSM: S_IDLE → S_CHECK on accepted command; S_CHECK walks unit u = 0..3N-1 (rows 0..N-1, cols N..2N-1, boxes 2N..3N-1), one unit per cycle, accumulating dup and empty flags; at u = 3N-1 → S_IDLE, `conflict`←dup_acc, `win`←!dup_acc & !empty_acc.
- Reset mid-check aborts to reset state; no partial flag update.

## Timing
- Cursor move: `cur_select` updates on the edge sampling the pulse.
- Write/undo/load: `cur_map` updates on the accepting edge; `busy` is 1 from that edge for exactly 3N cycles (27 for BOX=3); `win`/`conflict` update on the edge `busy` drops, hold old values while busy.
- Next command accepted the cycle `busy` reads 0.
- `undo_empty` reflects the history on the edge after push/pop/clear.

## Structure
- Package `sudoku_pkg`: `state_t` enum {S_IDLE, S_CHECK}, functions for N/CELLS/DW/IW from BOX, unit-to-cell-index function.
- Sub-module `sudoku_unit_check`: combinational, N digits in → `dup`, `has_empty` (seen-bitmask OR-reduction); instantiated once, fed by the FSM's unit mux.
- History stack, cursor and FSM in the top module.

## Test plan
- BOX=3, reset then 10 LEFT pulses → `cur_select`=8 (wrap to col 8, then back to 8 after 9 moves… final col = (0−10) mod 9 = 8), row 0.
- Load solved 9x9 grid with cell 0 cleared and mask 0 on cell 0; write 2 (the correct digit) → `busy` high 27 cycles, then `win`=1, `conflict`=0.
- Same puzzle, write duplicate digit in row 0 → `conflict`=1, `win`=0; `undo` → cell 0 = 0, `conflict`=0, `undo_empty`=1.
- Write to masked cell, or `num_code`=10 → `cur_map` unchanged, `busy` stays 0.
- 17 writes with UNDO_DEPTH=16, then 17 undos → first 16 revert, 17th no-op, first write's value remains.
- BOX=2: `load`+`num_valid` same cycle → load wins; `num_valid` during busy dropped; RST asserted mid-check → all outputs reset values.
